// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver; oversampled line, mid-bit start validation,
//            byte strobe and framing-error strobe.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk_i,
  input  logic       srst_i,
  input  logic       RxD_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int c_div  = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int c_sc_w = $clog2(OVERSAMPLE);
  localparam logic [c_sc_w-1:0] c_sc_half = c_sc_w'(OVERSAMPLE / 2 - 1);
  localparam logic [c_sc_w-1:0] c_sc_last = c_sc_w'(OVERSAMPLE - 1);
  localparam logic [c_sc_w-1:0] c_sc_one  = c_sc_w'(1);

  generate
    if (c_div < 1) begin : g_div_check
      $error("uart_rx: CLK_FREQ/(BAUD_RATE*OVERSAMPLE) must be at least 1");
    end
    if ((OVERSAMPLE % 2) != 0 || OVERSAMPLE < 4) begin : g_os_check
      $error("uart_rx: OVERSAMPLE must be even and >= 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  logic              sync1_q, sync2_q;
  logic              w_rx_s;
  logic              w_tick;
  state_t            state_q, state_d;
  logic [c_sc_w-1:0] sc_q, sc_d;
  logic [2:0]        bc_q, bc_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        data_q, data_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= RxD_i;
      sync2_q <= sync1_q;
    end
  end
  assign w_rx_s = sync2_q;

  generate
    if (c_div <= 1) begin : g_tick_every
      assign w_tick = 1'b1;
    end else begin : g_tick_div
      localparam int c_div_w = $clog2(c_div);
      localparam logic [c_div_w-1:0] c_div_last = c_div_w'(c_div - 1);
      logic [c_div_w-1:0] div_q;
      always_ff @(posedge clk_i) begin
        if (srst_i || div_q == c_div_last) begin
          div_q <= '0;
        end else begin
          div_q <= div_q + c_div_w'(1);
        end
      end
      assign w_tick = (div_q == c_div_last);
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= S_IDLE;
      sc_q    <= '0;
      bc_q    <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      bc_q    <= bc_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    bc_d    = bc_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    if (w_tick) begin
      unique case (state_q)
        S_IDLE: begin
          if (!w_rx_s) begin
            state_d = S_START;
            sc_d    = '0;
          end
        end
        S_START: begin
          // A high line at mid start bit means the falling edge was noise.
          if (sc_q == c_sc_half) begin
            if (w_rx_s) begin
              state_d = S_IDLE;
            end else begin
              sc_d    = '0;
              bc_d    = '0;
              state_d = S_DATA;
            end
          end else begin
            sc_d = sc_q + c_sc_one;
          end
        end
        S_DATA: begin
          if (sc_q == c_sc_last) begin
            shift_d = {w_rx_s, shift_q[7:1]};
            sc_d    = '0;
            bc_d    = bc_q + 3'd1;
            if (bc_q == 3'd7) begin
              state_d = S_STOP;
            end
          end else begin
            sc_d = sc_q + c_sc_one;
          end
        end
        S_STOP: begin
          if (sc_q == c_sc_last) begin
            sc_d = '0;
            if (w_rx_s) begin
              data_d  = shift_q;
              valid_d = 1'b1;
              state_d = S_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = S_WAIT_HIGH;
            end
          end else begin
            sc_d = sc_q + c_sc_one;
          end
        end
        S_WAIT_HIGH: begin
          if (w_rx_s) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Self-checking bench for uart_rx against a time-based line model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int CLK_FREQ   = 16000;
  localparam int BAUD_RATE  = 1000;
  localparam int OVERSAMPLE = 16;
  localparam int c_half     = OVERSAMPLE / 2;
  localparam int c_first    = c_half + OVERSAMPLE;
  localparam int c_last     = c_half + 8 * OVERSAMPLE;
  localparam int c_stop_t   = c_half + 9 * OVERSAMPLE;

  logic       clk_i  = 1'b0;
  logic       srst_i = 1'b1;
  logic       RxD_i  = 1'b1;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       busy_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_fall = 0;
  bit chk_en   = 1'b0;

  uart_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .OVERSAMPLE(OVERSAMPLE)
  ) dut (
    .clk_i      (clk_i),
    .srst_i     (srst_i),
    .RxD_i      (RxD_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .frame_err_o(frame_err_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line model: times are counted in ticks since the synchronised line was
  // first seen low; start checked at mid-bit, data and stop at bit centres.
  logic       m_rx1 = 1'b1, m_rx2 = 1'b1;
  int         m_mode = 0;
  int         m_t = 0;
  logic [7:0] m_bits = 8'h00, m_data = 8'h00;
  logic       m_valid = 1'b0, m_ferr = 1'b0;

  always @(posedge clk_i) begin
    if (srst_i) begin
      m_rx1 <= 1'b1; m_rx2 <= 1'b1; m_mode <= 0; m_t <= 0;
      m_bits <= 8'h00; m_data <= 8'h00; m_valid <= 1'b0; m_ferr <= 1'b0;
    end else begin
      m_rx1   <= RxD_i;
      m_rx2   <= m_rx1;
      m_valid <= 1'b0;
      m_ferr  <= 1'b0;
      case (m_mode)
        0: if (!m_rx2) begin m_mode <= 1; m_t <= 1; end
        1: begin
          m_t <= m_t + 1;
          if (m_t == c_half && m_rx2) m_mode <= 0;
          else if (m_t >= c_first && m_t <= c_last && (m_t - c_half) % OVERSAMPLE == 0)
            m_bits[(m_t - c_first) / OVERSAMPLE] <= m_rx2;
          else if (m_t == c_stop_t) begin
            if (m_rx2) begin m_data <= m_bits; m_valid <= 1'b1; m_mode <= 0; end
            else begin m_ferr <= 1'b1; m_mode <= 2; end
          end
        end
        default: if (m_rx2) m_mode <= 0;
      endcase
    end
  end

  int         ev_cyc[$];
  logic [7:0] ev_data[$];
  int         ferr_cnt = 0;
  int         busy_cnt = 0;

  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("valid_o", valid_o, m_valid);
      chk("frame_err_o", frame_err_o, m_ferr);
      chk("data_o", data_o, m_data);
      chk("busy_o", busy_o, (m_mode != 0));
      if (valid_o) begin ev_cyc.push_back(cyc); ev_data.push_back(data_o); end
      if (frame_err_o) ferr_cnt++;
      if (busy_o) busy_cnt++;
    end
  end

  function automatic logic [7:0] evd(input int i);
    return (i < ev_data.size()) ? ev_data[i] : 8'hxx;
  endfunction

  function automatic int evc(input int i);
    return (i < ev_cyc.size()) ? ev_cyc[i] : -100000;
  endfunction

  task automatic clear_log();
    ev_cyc.delete(); ev_data.delete(); ferr_cnt = 0; busy_cnt = 0;
  endtask

  task automatic hold(input logic v, input int n);
    RxD_i = v;
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int per, input logic stop);
    last_fall = cyc;
    hold(1'b0, per);
    for (int k = 0; k < 8; k++) hold(b[k], per);
    hold(stop, per);
  endtask

  logic [7:0] exp_q[$];
  int         exp_ferr;
  int         lat;
  logic [7:0] rb;
  logic       rs;

  initial begin
    @(posedge clk_i); #1;
    chk_en = 1'b1;
    chk("reset data_o", data_o, 8'h00);
    chk("reset valid_o", valid_o, 1'b0);
    chk("reset frame_err_o", frame_err_o, 1'b0);
    chk("reset busy_o", busy_o, 1'b0);
    @(posedge clk_i); #1;
    srst_i = 1'b0;
    hold(1'b1, 20);

    // Single byte
    clear_log();
    send(8'hA5, 16, 1'b1);
    lat = evc(0) - last_fall;
    hold(1'b1, 20);
    chk("s1 valid count", ev_data.size(), 1);
    chk("s1 data", evd(0), 8'hA5);
    chk("s1 frame_err count", ferr_cnt, 0);
    chk("s1 latency 155+-2", (lat >= 153 && lat <= 157), 1'b1);
    chk("s1 busy cycles", busy_cnt, 152);

    // Back-to-back
    clear_log();
    send(8'h00, 16, 1'b1);
    send(8'hFF, 16, 1'b1);
    send(8'h55, 16, 1'b1);
    hold(1'b1, 20);
    chk("s2 valid count", ev_data.size(), 3);
    chk("s2 data0", evd(0), 8'h00);
    chk("s2 data1", evd(1), 8'hFF);
    chk("s2 data2", evd(2), 8'h55);
    chk("s2 spacing01", ((evc(1) - evc(0)) >= 159 && (evc(1) - evc(0)) <= 161), 1'b1);
    chk("s2 spacing12", ((evc(2) - evc(1)) >= 159 && (evc(2) - evc(1)) <= 161), 1'b1);

    // Start glitch
    clear_log();
    hold(1'b0, 5);
    hold(1'b1, 12);
    chk("s3 busy after 12", busy_o, 1'b0);
    hold(1'b1, 20);
    chk("s3 valid count", ev_data.size(), 0);
    chk("s3 frame_err count", ferr_cnt, 0);
    chk("s3 busy short", (busy_cnt > 0 && busy_cnt <= 12), 1'b1);

    // Framing error then recovery
    clear_log();
    send(8'h3C, 16, 1'b0);
    hold(1'b0, 40);
    hold(1'b1, 40);
    chk("s4 frame_err count", ferr_cnt, 1);
    chk("s4 valid count", ev_data.size(), 0);
    chk("s4 data kept", data_o, 8'h55);
    clear_log();
    send(8'h81, 16, 1'b1);
    hold(1'b1, 20);
    chk("s4 recovery data", evd(0), 8'h81);
    chk("s4 recovery count", ev_data.size(), 1);

    // Reset during data bit 4 of 0xC3
    clear_log();
    hold(1'b0, 16);
    for (int k = 0; k < 4; k++) hold(k < 2 ? 1'b1 : 1'b0, 16);
    hold(1'b0, 8);
    srst_i = 1'b1;
    RxD_i  = 1'b1;
    @(posedge clk_i); #1;
    srst_i = 1'b0;
    chk("s5 data after reset", data_o, 8'h00);
    chk("s5 busy after reset", busy_o, 1'b0);
    chk("s5 valid after reset", valid_o, 1'b0);
    hold(1'b1, 30);
    chk("s5 no strobe", ev_data.size() + ferr_cnt, 0);
    send(8'h12, 16, 1'b1);
    hold(1'b1, 20);
    chk("s5 data", evd(0), 8'h12);

    // Baud tolerance
    clear_log();
    send(8'h96, 17, 1'b1);
    hold(1'b1, 20);
    chk("s6 slow data", evd(0), 8'h96);
    chk("s6 slow frame_err", ferr_cnt, 0);
    send(8'h96, 15, 1'b1);
    hold(1'b1, 30);
    chk("s6 fast count", ev_data.size(), 2);
    chk("s6 fast frame_err", ferr_cnt, 0);

    // Random frames with random gaps and occasional bad stop bits
    clear_log();
    exp_q.delete();
    exp_ferr = 0;
    for (int n = 0; n < 14; n++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 5) != 0);
      send(rb, 16, rs);
      if (rs) exp_q.push_back(rb);
      else exp_ferr++;
      hold(1'b1, rs ? $urandom_range(0, 24) : $urandom_range(3, 24));
    end
    hold(1'b1, 40);
    chk("rand valid count", ev_data.size(), exp_q.size());
    chk("rand frame_err count", ferr_cnt, exp_ferr);
    for (int i = 0; i < exp_q.size(); i++) chk("rand data", evd(i), exp_q[i]);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
